// File: rtl/fifo_seq_ctrl.sv
// fifo_seq_ctrl
// Sequencer for a DEPTH-stage shift-style delay buffer. It accepts LEN samples
// over a valid/ready input and drives the buffer's shift enable. It keeps a
// valid shadow of every stage, then flushes the buffer with zero bubbles until
// the last real sample has left, and finally pulses done.
// Optional feature macro: FIFO_SEQ_PERF_EN builds the stall_cycles counter.
// When the macro is undefined, stall_cycles is tied to zero.

module fifo_seq_ctrl #(
   parameter int DEPTH = 8,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             out_ready,
   output logic             shift_en,
   output logic             zero_sel,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic [31:0]      stall_cycles
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [DEPTH-1:0] r_vld;
   logic [LEN_W-1:0] r_lenQ;
   logic [LEN_W-1:0] r_inCnt;

   logic             w_run;
   logic             w_drain;
   logic             w_headVld;
   logic             w_go;
   logic             w_shiftEn;
   logic             w_accept;
   logic [DEPTH-1:0] w_vldNext;
   logic [LEN_W-1:0] w_inCntInc;

   // Handshake outputs must respond to in_valid/out_ready within the cycle.
   // They are therefore decoded from registered state and the handshake inputs.
   // The head stage may only move when it is empty or downstream takes it.
   assign w_run      = (r_state == RUN);
   assign w_drain    = (r_state == DRAIN);
   assign w_headVld  = r_vld[DEPTH-1];
   assign w_go       = (w_run & in_valid) | (w_drain & (|r_vld));
   assign w_shiftEn  = w_go & (~w_headVld | out_ready);
   assign w_accept   = w_run & in_valid & w_shiftEn;
   assign w_vldNext  = w_shiftEn ? {r_vld[DEPTH-2:0], w_run} : r_vld;
   assign w_inCntInc = r_inCnt + {{(LEN_W-1){1'b0}}, 1'b1};

   assign shift_en  = w_shiftEn;
   assign out_valid = w_go & w_headVld;
   assign in_ready  = w_run & (~w_headVld | out_ready);
   assign zero_sel  = w_drain;
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);

   // Main sequencer: transfer-length capture, input counting, valid shadow
   // tracking and state transitions. DRAIN exits on the edge that empties the
   // shadow, so done appears in the cycle right after the last sample leaves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_vld   <= '0;
         r_lenQ  <= '0;
         r_inCnt <= '0;
      end else begin
         r_vld <= w_vldNext;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_lenQ  <= len;
                  r_inCnt <= '0;
                  r_state <= (len == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (w_accept) begin
                  r_inCnt <= w_inCntInc;
                  if (w_inCntInc == r_lenQ) begin
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (w_vldNext == '0) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef FIFO_SEQ_PERF_EN
   logic [31:0] r_stallCycles;

   // Count cycles where a real head sample is held back by downstream.
   // The count saturates at its maximum and restarts on an accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stallCycles <= '0;
      end else if ((r_state == IDLE) && start) begin
         r_stallCycles <= '0;
      end else if (w_go && w_headVld && !out_ready && (r_stallCycles != 32'hFFFF_FFFF)) begin
         r_stallCycles <= r_stallCycles + 32'd1;
      end
   end

   assign stall_cycles = r_stallCycles;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_seq_ctrl.sv
// tb_fifo_seq_ctrl
// Bench for fifo_seq_ctrl. It includes a model delay buffer that the DUT drives,
// a scoreboard for sample order, and a token-position model of the transfer.
// Directed transfers use hand-computed event cycles.

module tb_fifo_seq_ctrl;

   localparam int DEPTH  = 8;
   localparam int LEN_W  = 16;
   localparam int P_IDLE  = 0;
   localparam int P_RUN   = 1;
   localparam int P_DRAIN = 2;
   localparam int P_DONE  = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic             in_ready;
   logic             out_ready;
   logic             shift_en;
   logic             zero_sel;
   logic             out_valid;
   logic             busy;
   logic             done;
   logic [31:0]      stall_cycles;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int t0       = 0;

   // Per-transfer event statistics, cycle numbers relative to the start cycle.
   int firstOv, doneAt, nOut, firstDrain, drainShifts, lastAccept, busyCnt, shiftCnt;

   // Model state: phase, stage position of each in-flight real sample (oldest first).
   int          mPhase = P_IDLE;
   int          mPos[$];
   int          mLen, mInCnt;
   longint      mStall;
   logic [15:0] expQ[$];

   logic [15:0] bufData[DEPTH];
   logic [15:0] inData = 16'h0100;

   always #5 clk = ~clk;

   fifo_seq_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .len(len),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_ready(out_ready),
      .shift_en(shift_en),
      .zero_sel(zero_sel),
      .out_valid(out_valid),
      .busy(busy),
      .done(done),
      .stall_cycles(stall_cycles)
   );

   // Free-running cycle counter used to time-stamp events.
   always @(posedge clk) cyc <= cyc + 1;

   // Delay buffer controlled by the DUT, plus the upstream sample source.
   always @(posedge clk) begin
      if (shift_en) begin
         bufData[0] <= zero_sel ? 16'h0000 : inData;
         for (int i = 1; i < DEPTH; i++) bufData[i] <= bufData[i-1];
      end
      if (in_valid && in_ready) inData <= inData + 16'd1;
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic clearStats();
      firstOv = -1; doneAt = -1; nOut = 0; firstDrain = -1;
      drainShifts = 0; lastAccept = -1; busyCnt = 0; shiftCnt = 0;
   endtask

   task automatic modelReset();
      mPhase = P_IDLE;
      mPos.delete();
      mLen = 0;
      mInCnt = 0;
      mStall = 0;
      expQ.delete();
   endtask

   // Outputs the rules require, given model phase, samples in flight and handshake inputs.
   // Bits: {shift, outValid, inReady, zeroSel, busy, done}.
   function automatic logic [5:0] modelOut();
      bit run, drain, head, go;
      run   = (mPhase == P_RUN);
      drain = (mPhase == P_DRAIN);
      head  = (mPos.size() > 0) && (mPos[0] == DEPTH-1);
      go    = (run && in_valid) || (drain && mPos.size() > 0);
      return {go && (!head || out_ready), go && head, run && (!head || out_ready),
              drain, mPhase != P_IDLE, mPhase == P_DONE};
   endfunction

   task automatic modelAdvance(input logic [5:0] o);
      bit run;
      run = (mPhase == P_RUN);
      if (o[4] && !out_ready && mStall != 64'hFFFF_FFFF) mStall++;
      if (o[5]) begin
         if (mPos.size() > 0 && mPos[0] == DEPTH-1) void'(mPos.pop_front());
         foreach (mPos[i]) mPos[i]++;
         if (run) mPos.push_back(0);
      end
      case (mPhase)
         P_IDLE: if (start) begin
            mLen = int'(len);
            mInCnt = 0;
            mStall = 0;
            mPhase = (len == 0) ? P_DONE : P_RUN;
         end
         P_RUN: if (o[5]) begin
            mInCnt++;
            if (mInCnt == mLen) mPhase = P_DRAIN;
         end
         P_DRAIN: if (mPos.size() == 0) mPhase = P_DONE;
         default: mPhase = P_IDLE;
      endcase
   endtask

   // Compare process. Each cycle, check the DUT against the model away from the edge.
   // Score sample order, then advance the model with the inputs the next edge sees.
   always @(negedge clk) begin : cmp
      logic [5:0] o;
      int rel;
      longint expStall;
      if (rst) modelReset();
      o = modelOut();
      rel = cyc - t0;
`ifdef FIFO_SEQ_PERF_EN
      expStall = mStall;
`else
      expStall = 0;
`endif
      checkOutput("shift_en", shift_en, o[5]);
      checkOutput("out_valid", out_valid, o[4]);
      checkOutput("in_ready", in_ready, o[3]);
      checkOutput("zero_sel", zero_sel, o[2]);
      checkOutput("busy", busy, o[1]);
      checkOutput("done", done, o[0]);
      checkOutput("stall_cycles", stall_cycles, expStall);
      if (!rst) begin
         if (out_valid && out_ready) begin
            nOut++;
            if (firstOv < 0) firstOv = rel;
            if (expQ.size() == 0) checkOutput("sb_extra_output", 1, 0);
            else checkOutput("sb_data", bufData[DEPTH-1], expQ.pop_front());
         end
         if (in_valid && in_ready) begin
            expQ.push_back(inData);
            lastAccept = rel;
         end
         if (shift_en) shiftCnt++;
         if (shift_en && zero_sel) begin
            drainShifts++;
            if (firstDrain < 0) firstDrain = rel;
         end
         if (busy) busyCnt++;
         if (done) doneAt = rel;
         modelAdvance(o);
      end
   end

   // Run one transfer. Start goes high in cycle 0 and len is then changed to restartLen.
   // Optional pieces: start re-pulsed at restartAt, out_ready low in [stallLo, stallHi],
   // in_valid gaps every third cycle, and an async reset in cycle resetAt.
   task automatic applyStimulus(input int length, input int stallLo, input int stallHi,
                                input int restartAt, input int restartLen,
                                input int resetAt, input bit gap);
      bit aborted;
      int rel;
      aborted = 0;
      @(posedge clk); #1;
      clearStats();
      t0 = cyc;
      start = 1'b1;
      len = LEN_W'(length);
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         rel = cyc - t0;
         start = (rel == restartAt);
         len = LEN_W'(restartLen);
         out_ready = !(rel >= stallLo && rel <= stallHi);
         in_valid = !(gap && (rel % 3 == 0));
         if (rel == resetAt) begin
            #2;
            checkOutput("pre_rst_shift_en", shift_en, 1);
            checkOutput("pre_rst_out_valid", out_valid, 1);
            rst = 1'b1;
            #1;
            checkOutput("rst_shift_en", shift_en, 0);
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_in_ready", in_ready, 0);
            checkOutput("rst_zero_sel", zero_sel, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            @(posedge clk); #1;
            rst = 1'b0;
            aborted = 1;
            break;
         end
         if (doneAt >= 0 && !done) break;
      end
      if (!aborted) checkOutput("done_seen", doneAt >= 0, 1);
      start = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      longint expStall3;
      rst = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b0;
      clearStats();
      #2 rst = 1'b1;
      #2;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_shift_en", shift_en, 0);
      checkOutput("reset_stall_cycles", stall_cycles, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;

      // len=4, free flow
      applyStimulus(4, -1, -2, -1, 7, -1, 0);
      checkOutput("t1_first_out", firstOv, 9);
      checkOutput("t1_last_accept", lastAccept, 4);
      checkOutput("t1_first_drain", firstDrain, 5);
      checkOutput("t1_drain_shifts", drainShifts, 8);
      checkOutput("t1_outputs", nOut, 4);
      checkOutput("t1_done_cycle", doneAt, 13);
      checkOutput("t1_busy_after", busy, 0);

      // len=10, output overlaps input
      applyStimulus(10, -1, -2, -1, 3, -1, 0);
      checkOutput("t2_first_out", firstOv, 9);
      checkOutput("t2_last_accept", lastAccept, 10);
      checkOutput("t2_first_drain", firstDrain, 11);
      checkOutput("t2_drain_shifts", drainShifts, 8);
      checkOutput("t2_outputs", nOut, 10);
      checkOutput("t2_done_cycle", doneAt, 19);

      // len=12, downstream stalls cycles 10-14
      applyStimulus(12, 10, 14, -1, 1, -1, 0);
`ifdef FIFO_SEQ_PERF_EN
      expStall3 = 5;
`else
      expStall3 = 0;
`endif
      checkOutput("t3_first_out", firstOv, 9);
      checkOutput("t3_last_accept", lastAccept, 17);
      checkOutput("t3_outputs", nOut, 12);
      checkOutput("t3_done_cycle", doneAt, 26);
      checkOutput("t3_stall_cycles", stall_cycles, expStall3);

      // len=0 goes straight to done
      applyStimulus(0, -1, -2, -1, 5, -1, 0);
      checkOutput("t4_done_cycle", doneAt, 1);
      checkOutput("t4_shift_count", shiftCnt, 0);
      checkOutput("t4_busy_cycles", busyCnt, 1);
      checkOutput("t4_outputs", nOut, 0);
      checkOutput("t4_stall_cleared", stall_cycles, 0);

      // len=6 with async reset mid-drain, then len=2 recovers
      applyStimulus(6, -1, -2, -1, 6, 9, 0);
      applyStimulus(2, -1, -2, -1, 8, -1, 0);
      checkOutput("t5_outputs", nOut, 2);
      checkOutput("t5_done_cycle", doneAt, 11);

      // start re-pulsed with len=9 during RUN of len=5 is ignored
      applyStimulus(5, -1, -2, 2, 9, -1, 0);
      checkOutput("t6_outputs", nOut, 5);
      checkOutput("t6_done_cycle", doneAt, 14);

      // len=5 with upstream gaps every third cycle
      applyStimulus(5, -1, -2, -1, 2, -1, 1);
      checkOutput("t7_last_accept", lastAccept, 7);
      checkOutput("t7_first_out", firstOv, 11);
      checkOutput("t7_outputs", nOut, 5);
      checkOutput("t7_done_cycle", doneAt, 16);
      checkOutput("t7_queue_empty", expQ.size(), 0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
